// File: rtl/m6502_bus_pkg.sv
// Shared types and constants for the 6502-style phi2 bus initiator.
// Bus width constants, R/W encodings, the request record and a counter-width helper.
package m6502_bus_pkg;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 8;

    typedef struct packed {
        logic                  we;
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
    } bus_req_t;

    function automatic int phase_cnt_w(input int phase_clks);
        return $clog2(2 * phase_clks);
    endfunction

endpackage

// File: rtl/bus_phase_gen.sv
// Free-running phi2 generator: phase counter, registered phi2 and the
// launch (cnt 0->1) / sample (cnt wraps to 0) strobes.
module bus_phase_gen
    import m6502_bus_pkg::*;
#(
    parameter int PHASE_CLKS = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_phi2,
    output logic o_launch,
    output logic o_sample
);

    localparam int CNT_W = phase_cnt_w(PHASE_CLKS);
    localparam int LAST  = 2 * PHASE_CLKS - 1;

    generate
        if (PHASE_CLKS < 2) begin : g_bad_phase
            $error("bus_phase_gen: PHASE_CLKS must be >= 2");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phi2_q;

    always_comb begin
        cnt_d = (cnt_q == CNT_W'(LAST)) ? '0 : cnt_q + 1'b1;
    end

    // phi2 follows the counter value being loaded, so it changes on the same edge as cnt
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            phi2_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            phi2_q <= (cnt_d >= CNT_W'(PHASE_CLKS));
        end
    end

    assign o_phi2   = phi2_q;
    assign o_launch = (cnt_q == '0);
    assign o_sample = (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/bus_master.sv
// Initiator for the phi2 bus: one-entry request buffer, bus drivers held from
// launch through sample, and a one-clock response pulse per completed transfer.
module bus_master
    import m6502_bus_pkg::*;
#(
    parameter int PHASE_CLKS = 2,
    parameter int ADDR_W     = BUS_ADDR_W,
    parameter int DATA_W     = BUS_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    output logic              o_rsp_we,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_phi2,
    output logic              o_rw,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy
);

    // The request record is sized to the 6502 bus, so the port widths must match it.
    generate
        if (ADDR_W != BUS_ADDR_W || DATA_W != BUS_DATA_W) begin : g_bad_width
            $error("bus_master: ADDR_W/DATA_W must match the bus_req_t field widths");
        end
    endgenerate

    logic launch, sample;

    bus_phase_gen #(
        .PHASE_CLKS (PHASE_CLKS)
    ) u_phase (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .o_phi2   (o_phi2),
        .o_launch (launch),
        .o_sample (sample)
    );

    bus_req_t          req_q, req_d;
    logic              pending_q, pending_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        req_d       = req_q;
        pending_d   = pending_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_d      = data_q;
        busy_d      = busy_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;

        if (launch) begin
            if (pending_q) begin
                addr_d    = req_q.addr;
                rw_d      = req_q.we ? RW_WRITE : RW_READ;
                data_d    = req_q.wdata;
                busy_d    = 1'b1;
                pending_d = 1'b0;
            end else begin
                rw_d   = RW_READ;
                busy_d = 1'b0;
            end
        end else if (sample) begin
            if (busy_q) begin
                rsp_valid_d = 1'b1;
                rsp_we_d    = (rw_q == RW_WRITE);
                if (rw_q == RW_READ) begin
                    rsp_rdata_d = i_data;
                end
            end
            busy_d = 1'b0;
        end

        // A launch only consumes pending when it is already set, so this never collides with it
        if (i_req_valid && !pending_q) begin
            pending_d = 1'b1;
            req_d     = '{we: i_req_we, addr: i_req_addr, wdata: i_req_wdata};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q       <= '0;
            pending_q   <= 1'b0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            req_q       <= req_d;
            pending_q   <= pending_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign o_req_ready = !pending_q;
    assign o_rw        = rw_q;
    assign o_addr      = addr_q;
    assign o_data      = data_q;
    assign o_busy      = busy_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_we    = rsp_we_q;
    assign o_rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Scoreboard bench for bus_master with PHASE_CLKS = 2 and a behavioural phi2 RAM responder.
module tb_bus_master;

    localparam int PC = 2;
    localparam int AW = 16;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic          i_req_we = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic [DW-1:0] i_req_wdata = '0;
    logic          o_rsp_valid;
    logic          o_rsp_we;
    logic [DW-1:0] o_rsp_rdata;
    logic          o_phi2;
    logic          o_rw;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic [DW-1:0] i_data;
    logic          o_busy;

    always #5 clk = ~clk;

    bus_master #(
        .PHASE_CLKS (PC),
        .ADDR_W     (AW),
        .DATA_W     (DW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_we    (i_req_we),
        .i_req_addr  (i_req_addr),
        .i_req_wdata (i_req_wdata),
        .o_rsp_valid (o_rsp_valid),
        .o_rsp_we    (o_rsp_we),
        .o_rsp_rdata (o_rsp_rdata),
        .o_phi2      (o_phi2),
        .o_rw        (o_rw),
        .o_addr      (o_addr),
        .o_data      (o_data),
        .i_data      (i_data),
        .o_busy      (o_busy)
    );

    // Responder: drives read data from the current address, writes on phi2 falling
    logic [DW-1:0] mem [0:65535];
    int            n_writes = 0;
    assign i_data = mem[o_addr];
    always @(negedge o_phi2) begin
        if (rst_n && o_rw == 1'b0) begin
            mem[o_addr] = o_data;
            n_writes++;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit      we;
        logic [DW-1:0] rdata;
        int      acc;
        int      lat;
        int      gap;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            n_vec = 0;
    int            n_bad = 0;
    int            last_rsp = -1;
    logic [DW-1:0] exp_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && o_rsp_valid) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_rsp: got we=%0b rdata=0x%0h, expected no response (cyc=%0d)",
                         o_rsp_we, o_rsp_rdata, cyc);
            end else begin
                mon_e = sb.pop_front();
                $display("rsp cyc=%0d we=%0b rdata=0x%0h", cyc, o_rsp_we, o_rsp_rdata);
                chk("rsp_we", 32'(o_rsp_we), 32'(mon_e.we));
                chk("rsp_rdata", 32'(o_rsp_rdata), 32'(mon_e.rdata));
                if (mon_e.lat >= 0) chk("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
                if (mon_e.gap >= 0) chk("rsp_gap", 32'(cyc - last_rsp), 32'(mon_e.gap));
            end
            last_rsp = cyc;
        end
    end

    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [DW-1:0] rd_exp, input int lat, input int gap,
                        input bit keep, input bit push);
        exp_t e;
        int   k;
        i_req_we    = we;
        i_req_addr  = a;
        i_req_wdata = wd;
        i_req_valid = 1'b1;
        k = 0;
        while (!o_req_ready && k < 64) begin
            @(negedge clk);
            k++;
        end
        if (!o_req_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL req_ready_timeout: got ready=0, expected ready=1 within 64 clocks");
            i_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        $display("req cyc=%0d we=%0b addr=0x%0h wdata=0x%0h", cyc, we, a, wd);
        if (push) begin
            e.we    = we;
            e.rdata = we ? exp_last : rd_exp;
            if (!we) exp_last = rd_exp;
            e.acc   = cyc;
            e.lat   = lat;
            e.gap   = gap;
            sb.push_back(e);
        end
        if (!keep) i_req_valid = 1'b0;
    endtask

    // Leaves the bench at the negedge just after phi2 fell (cnt = 0, next edge launches)
    task automatic align_fall();
        logic prev;
        int   k;
        @(negedge clk);
        prev = o_phi2;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (prev && !o_phi2) break;
            prev = o_phi2;
        end while (k < 16);
        if (k >= 16) begin
            n_vec++;
            n_bad++;
            $display("FAIL phi2_fall_timeout: got no phi2 fall, expected one within 16 clocks");
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d outstanding, expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] phi_seq;
        int         w0;
        int         bad_idle;
        int         k;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h1233] = 8'h33;
        mem[16'h1235] = 8'h55;
        mem[16'h3000] = 8'h9C;
        mem[16'h0000] = 8'h11;
        mem[16'h0001] = 8'h22;
        mem[16'h0002] = 8'h33;
        mem[16'h0003] = 8'h44;

        // Reset hold
        repeat (5) @(negedge clk);
        chk("reset_phi2", 32'(o_phi2), 32'h0);
        chk("reset_rw", 32'(o_rw), 32'h1);
        chk("reset_ready", 32'(o_req_ready), 32'h1);
        chk("reset_rsp_valid", 32'(o_rsp_valid), 32'h0);
        rst_n = 1'b1;

        // phi2 after release: cnt 1,2,3,0,1,2,3,0 -> 0,1,1,0,0,1,1,0
        phi_seq = '0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            phi_seq = {phi_seq[6:0], o_phi2};
        end
        chk("phi2_waveform", 32'(phi_seq), 32'h66);

        // Write then read back
        send(1'b1, 16'h1234, 8'hA5, 8'h00, -1, -1, 1'b0, 1'b1);
        send(1'b0, 16'h1234, 8'h00, 8'hA5, -1, -1, 1'b0, 1'b1);
        drain();
        chk("mem_1234", 32'(mem[16'h1234]), 32'hA5);
        chk("mem_1233", 32'(mem[16'h1233]), 32'h33);
        chk("mem_1235", 32'(mem[16'h1235]), 32'h55);

        // Streaming reads with valid held high
        send(1'b0, 16'h0000, 8'h00, 8'h11, -1, -1, 1'b1, 1'b1);
        send(1'b0, 16'h0001, 8'h00, 8'h22, -1, 4, 1'b1, 1'b1);
        send(1'b0, 16'h0002, 8'h00, 8'h33, -1, 4, 1'b1, 1'b1);
        send(1'b0, 16'h0003, 8'h00, 8'h44, -1, 4, 1'b0, 1'b1);
        drain();

        // Accept on the cnt->0 edge: minimum latency
        align_fall();
        repeat (3) @(negedge clk);
        send(1'b0, 16'h0002, 8'h00, 8'h33, 4, -1, 1'b0, 1'b1);
        drain();

        // Accept on the launch edge: maximum latency
        align_fall();
        send(1'b0, 16'h0001, 8'h00, 8'h22, 7, -1, 1'b0, 1'b1);
        drain();

        // Idle bus cycles
        w0 = n_writes;
        bad_idle = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (o_rw !== 1'b1 || o_busy !== 1'b0) bad_idle++;
        end
        chk("idle_rw_busy_violations", 32'(bad_idle), 32'h0);
        chk("idle_write_count", 32'(n_writes), 32'(w0));

        // Reset while phi2 is high during a write
        align_fall();
        send(1'b1, 16'h2000, 8'h77, 8'h00, -1, -1, 1'b0, 1'b0);
        k = 0;
        while (!(o_busy && o_phi2) && k < 16) begin
            @(negedge clk);
            k++;
        end
        chk("write_reached_phi2_high", 32'(o_busy && o_phi2), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_phi2", 32'(o_phi2), 32'h0);
        chk("midrst_rw", 32'(o_rw), 32'h1);
        chk("midrst_busy", 32'(o_busy), 32'h0);
        chk("midrst_ready", 32'(o_req_ready), 32'h1);
        chk("midrst_addr", 32'(o_addr), 32'h0);
        chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'h0);
        exp_last = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        send(1'b0, 16'h3000, 8'h00, 8'h9C, -1, -1, 1'b0, 1'b1);
        drain();
        repeat (8) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Synchronous initiator for the 6502-style phi2 bus; it is the counterpart of the bus RAM responder.
- It divides a single system clock into a free-running phi2 and turns queued read/write requests into bus cycles: address/rw/data are set up while phi2 is low, the responder reads on the phi2 rising edge and writes on the falling edge.
- Read data is sampled at the end of phi2-high and returned as a one-clock response pulse.
- Used as a testbench/DMA driver in place of, or alongside, the CPU core.

Parameters:
- PHASE_CLKS, 2, i_clk cycles per phi2 phase; legal values >= 2; bus cycle = 2*PHASE_CLKS clocks.
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.

Ports:
- i_clk  input  1  system clock; all state changes on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  request present.
- o_req_ready  output  1  request holding register empty; equals !pending.
- i_req_we  input  1  1 = write, 0 = read.
- i_req_addr  input  ADDR_W  request address.
- i_req_wdata  input  DATA_W  write data.
- o_rsp_valid  output  1  one-clock pulse: transfer completed.
- o_rsp_we  output  1  type of the completed transfer.
- o_rsp_rdata  output  DATA_W  sampled read data; holds its previous value on write completion.
- o_phi2  output  1  bus clock.
- o_rw  output  1  bus R/W; 1 = read.
- o_addr  output  ADDR_W  bus address.
- o_data  output  DATA_W  bus write data.
- i_data  input  DATA_W  bus read data from the responder.
- o_busy  output  1  bus cycle in progress is a real transfer.

Behaviour:
- Phase counter cnt runs 0..2*PHASE_CLKS-1 and wraps; it never stops.
- o_phi2 is registered, high iff cnt >= PHASE_CLKS.
- Falling edge of phi2 is the clock edge where cnt wraps to 0. Rising edge is where cnt becomes PHASE_CLKS.
- Launch edge, cnt 0->1 (one clock after phi2 falls, so bus signals never change on the phi2 falling edge):
  - If pending: drive o_addr = req addr, o_rw = !we, o_data = wdata; set o_busy = 1; clear pending.
  - Else (idle cycle): o_rw = 1, o_addr and o_data hold, o_busy = 0.
- Sample edge, cnt wraps to 0 (same edge phi2 falls):
  - If o_busy: o_rsp_valid = 1 for exactly one clock; o_rsp_we = !o_rw.
  - On a read, o_rsp_rdata <= i_data.
  - o_busy <= 0.
- o_addr, o_rw and o_data are stable from the launch edge through the sample edge inclusive. A write therefore holds address and data across the responder's negedge-phi2 write.
- Request handshake:
  - Accept on a clock where i_req_valid && o_req_ready; latch we/addr/wdata and set pending.
  - One-entry buffer; o_req_ready = !pending.
  - Accept and launch cannot coincide, since ready is 0 whenever a launch consumes pending.
- Latency, accept edge to o_rsp_valid:
  - Minimum 2*PHASE_CLKS clocks, when accepted on the cnt->0 edge.
  - Maximum 4*PHASE_CLKS-1 clocks, when accepted on the launch edge.
- Throughput: one transfer per bus cycle when the requester refills between launches.
- Responses have no backpressure.
- Reset values (async on i_rst_n low): cnt = 0, o_phi2 = 0, o_rw = 1, o_addr = 0, o_data = 0, o_busy = 0, pending = 0 (so o_req_ready = 1), o_rsp_valid = 0, o_rsp_we = 0, o_rsp_rdata = 0.
- Reset mid-operation: the transfer is dropped and no response is issued. Forcing phi2 low and rw high together means the write may or may not land; benches must not rely on it.
- Illegal PHASE_CLKS < 2: elaboration-time $error.

Decomposition:
- Package m6502_bus_pkg holds:
  - RW_READ = 1'b1, RW_WRITE = 1'b0.
  - Struct bus_req_t {we, addr, wdata}.
  - Localparam helper for counter width: $clog2(2*PHASE_CLKS).
- Sub-module bus_phase_gen holds cnt, registered o_phi2, and the launch/sample strobes. bus_master holds the request register, bus drivers and response logic.

Test Plan:
All scenarios use PHASE_CLKS = 2 with a bus_ram responder attached.
- Reset: hold i_rst_n low 5 clocks -> o_phi2 = 0, o_rw = 1, o_req_ready = 1, o_rsp_valid = 0. After release, o_phi2 period is 4 clocks with 50% duty.
- Write/read: write 0x1234 = 0xA5, then read 0x1234 -> two rsp pulses; the second has o_rsp_we = 0 and o_rsp_rdata = 0xA5. Memory at 0x1233 and 0x1235 is unchanged.
- Streaming: preload 0x0000..0x0003 = 11,22,33,44 and keep i_req_valid high with reads of 0..3 -> four responses 4 clocks apart, in order 0x11, 0x22, 0x33, 0x44.
- Latency: request accepted on the cnt->0 edge -> rsp exactly 4 clocks later. Request accepted on the launch edge -> rsp 7 clocks later.
- Idle: no requests for 10 bus cycles -> o_rw = 1 and o_busy = 0 throughout, no rsp pulses, memory image unchanged.
- Reset mid-write: assert i_rst_n low while phi2 is high during a write -> outputs immediately at reset values and no rsp pulse. A following read of another address returns correct data.
